// File: rtl/coprime_pkg.sv
// Shared definitions for the coprime generator: FSM state encoding and
// operand-width constants.
package coprime_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_K         = (1 << DEFAULT_WIDTH) - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_STREAM  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/coprime_gen_gcd_unit.sv
// Iterative subtractive GCD. A load captures both operands. Each busy cycle
// replaces the larger operand by the difference. result_valid is raised
// combinationally on the cycle the operands meet, and the unit frees itself
// on that same edge. Operands must be non-zero or the loop never converges.
module gcd_unit
    import coprime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Operand registers: load, then subtract until equal
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (load && !busy) begin
            busy <= 1'b1;
            a_q  <= a_in;
            b_q  <= b_in;
        end else if (busy) begin
            if (a_q == b_q) begin
                busy <= 1'b0;
            end else if (a_q > b_q) begin
                a_q <= a_q - b_q;
            end else begin
                b_q <= b_q - a_q;
            end
        end
    end

    assign result_valid = busy && (a_q == b_q);
    assign result       = a_q;

endmodule

// File: rtl/coprime_gen.sv
// Coprime generator top: for operand n, tests every k in 1..2^WIDTH-1 with a
// shared gcd_unit, records hits in a bitmask, then streams the set bits in
// ascending order over a valid/ready handshake.
module coprime_gen
    import coprime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_last,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    localparam int               MASK_W = 1 << WIDTH;
    localparam logic [WIDTH-1:0] K_LAST = '1;

    state_t            state;
    logic [WIDTH-1:0]  n_q;
    logic [WIDTH-1:0]  k_q;
    logic [MASK_W-1:0] mask_q;
    logic              wait_gcd;

    logic              gcd_load;
    logic              gcd_busy;
    logic              gcd_valid;
    logic [WIDTH-1:0]  gcd_result;

    logic              skip_k;
    logic              step_done;
    logic              hit;
    logic              handshake;
    logic [MASK_W-1:0] mask_nxt;
    logic [WIDTH-1:0]  count_nxt;
    logic [WIDTH-1:0]  low_idx;
    logic              more_above;

    gcd_unit #(.WIDTH(WIDTH)) u_gcd (
        .clk          (clk),
        .rst          (rst),
        .load         (gcd_load),
        .a_in         (n_q),
        .b_in         (k_q),
        .busy         (gcd_busy),
        .result_valid (gcd_valid),
        .result       (gcd_result)
    );

    // Per-k sequencing: n==0 and k==n are skipped in one cycle, others go through the gcd_unit
    always_comb begin
        skip_k    = (n_q == '0) || (k_q == n_q);
        gcd_load  = 1'b0;
        step_done = 1'b0;
        hit       = 1'b0;
        if (state == ST_COMPUTE) begin
            if (!wait_gcd) begin
                if (skip_k) begin
                    step_done = 1'b1;
                end else begin
                    gcd_load = !gcd_busy;
                end
            end else if (gcd_valid) begin
                step_done = 1'b1;
                hit       = (gcd_result == WIDTH'(1));
            end
        end
    end

    // Next mask/count: set on a coprime hit, clear the bit just handed off
    always_comb begin
        mask_nxt  = mask_q;
        count_nxt = count;
        handshake = (state == ST_STREAM) && out_valid && out_ready;
        if (hit) begin
            mask_nxt[k_q] = 1'b1;
            count_nxt     = count + WIDTH'(1);
        end
        if (handshake) begin
            mask_nxt[out_value] = 1'b0;
        end
    end

    // Priority scanner on the next mask so the output register can reload with no bubble
    always_comb begin
        low_idx    = '0;
        more_above = 1'b0;
        for (int i = MASK_W - 1; i >= 1; i--) begin
            if (mask_nxt[WIDTH'(i)]) low_idx = WIDTH'(i);
        end
        for (int i = 1; i < MASK_W; i++) begin
            if (mask_nxt[WIDTH'(i)] && (WIDTH'(i) > low_idx)) more_above = 1'b1;
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            mask_q    <= '0;
            wait_gcd  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mask_q <= mask_nxt;
            count  <= count_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q      <= n_in;
                        k_q      <= WIDTH'(1);
                        mask_q   <= '0;
                        count    <= '0;
                        wait_gcd <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (gcd_load) wait_gcd <= 1'b1;
                    if (step_done) begin
                        wait_gcd <= 1'b0;
                        if (k_q == K_LAST) begin
                            if (count_nxt == '0) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                out_valid <= 1'b1;
                                out_value <= low_idx;
                                out_last  <= !more_above;
                                state     <= ST_STREAM;
                            end
                        end else begin
                            k_q <= k_q + WIDTH'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            out_value <= low_idx;
                            out_last  <= !more_above;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coprime_gen.sv
// Scoreboard bench for coprime_gen: directed operands with hand-derived
// coprime masks; a monitor pops expected {last,value} words on each handshake.
module tb_coprime_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] n_in;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_value;
    logic       out_last;
    logic [3:0] count;
    logic       done;

    logic [4:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [4:0] prev_word = '0;

    coprime_gen #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_in      (n_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_last  (out_last),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on handshake, stall stability, done pulse count
    initial begin
        logic [4:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_word", int'({out_last, out_value}), int'(prev_word));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", int'({out_last, out_value}), 0);
                        if ({out_last, out_value} == 5'd0) begin
                            n_err++;
                            $display("FAIL unexpected_out: got value 0 with no expectation");
                        end
                    end else begin
                        w = exp_q.pop_front();
                        chk("out_value", int'(out_value), int'(w[3:0]));
                        chk("out_last", int'(out_last), int'(w[4]));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_last, out_value};
                if (done) done_cnt++;
            end
        end
    end

    task automatic push_mask(input logic [15:0] emask);
        logic [15:0] above;
        for (int i = 1; i < 16; i++) begin
            if (emask[i]) begin
                above = emask >> (i + 1);
                exp_q.push_back({(above == 16'd0), 4'(i)});
            end
        end
    endtask

    task automatic pulse_start(input logic [3:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One full run; exp_lat < 0 disables the done-latency check
    task automatic run_vec(input logic [3:0] n, input logic [15:0] emask, input int ecnt,
                           input bit rnd, input bit poke, input int exp_lat);
        bit got_done;
        int lat;
        int d0;
        push_mask(emask);
        out_ready = 1'b1;
        pulse_start(n);
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        d0 = done_cnt;
        got_done = 1'b0;
        lat = -1;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (c == 40);
            n_in      = (poke && (c == 40)) ? 4'd3 : n;
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                lat = c;
            end
        end
        start = 1'b0;
        chk("done_seen", int'(got_done), 1);
        if (got_done) begin
            chk("busy_at_done", int'(busy), 1);
            chk("count", int'(count), ecnt);
            chk("queue_drained", exp_q.size(), 0);
            if (exp_lat >= 0) chk("done_latency", lat, exp_lat);
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
            chk("busy_dropped", int'(busy), 0);
            chk("done_pulses", done_cnt - d0, 1);
            chk("count_held", int'(count), ecnt);
        end
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        n_in      = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_value", int'(out_value), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_done", int'(done), 0);

        // n=6: 1,5,7,11,13
        run_vec(4'd6, 16'h28A2, 5, 1'b0, 1'b0, -1);
        // n=15: 1,2,4,7,8,11,13,14
        run_vec(4'd15, 16'h6996, 8, 1'b0, 1'b0, -1);
        // n=1: 2..15
        run_vec(4'd1, 16'hFFFC, 14, 1'b0, 1'b0, -1);
        // n=0: nothing streamed, done right after the 15 skip cycles
        run_vec(4'd0, 16'h0000, 0, 1'b0, 1'b0, 14);
        // n=6 with random backpressure
        run_vec(4'd6, 16'h28A2, 5, 1'b1, 1'b0, -1);
        // n=6 with a start pulse while busy
        run_vec(4'd6, 16'h28A2, 5, 1'b0, 1'b1, -1);

        // Reset during STREAM after two handshakes
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b0, 4'd5});
        out_ready = 1'b0;
        pulse_start(4'd6);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("stream_reached", int'(seen), 1);
        d0 = done_cnt;
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_value", int'(out_value), 0);
        chk("midrst_out_last", int'(out_last), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_handshakes", exp_q.size(), 0);
        repeat (50) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        exp_q.delete();

        // n=10 after reset: 1,3,7,9,11,13 (15 shares factor 5)
        run_vec(4'd10, 16'h2A8A, 6, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
